univ_shift_reg: RTL



---
 rtl/univ_shift_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - N-bit universal shift register with autonomous serial-burst mode

// Storage element: W-bit D flip-flop bank with synchronous active-high reset.
module univ_shift_reg_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture next value each edge; reset forces zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// Universal register: hold, shift, rotate, load and an N-edge LSB-first burst.
module univ_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_n,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] D,
  input  logic         sin_r,
  input  logic         sin_l,
  output logic [N-1:0] Q,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  // FSM encoding kept as plain constants so older tools read it unchanged.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Counter value at which the next burst edge is the N-th shift.
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_BURST = 3'b110;

  logic [N-1:0]  r_q;
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [N-1:0]  w_q_next;
  logic [0:0]    w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_done_next;

  // Data storage lives in the shared flip-flop element.
  univ_shift_reg_dff #(
    .W (N)
  ) u_q_dff (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_q_next),
    .o_q   (r_q)
  );

  // Next-state selection: clear beats an active burst, which beats en/mode.
  always_comb begin
    w_q_next     = r_q;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;

    if (!clear_n) begin
      // Abort without a done pulse.
      w_q_next     = '0;
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else if (r_state == ST_BURST) begin
      w_q_next = {sin_r, r_q[N-1:1]};
      if (r_cnt == CNT_LAST) begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_done_next  = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else if (en) begin
      case (mode)
        MODE_HOLD:  w_q_next = r_q;
        MODE_SHR:   w_q_next = {sin_r, r_q[N-1:1]};
        MODE_SHL:   w_q_next = {r_q[N-2:0], sin_l};
        MODE_LOAD:  w_q_next = D;
        MODE_ROR:   w_q_next = {r_q[0], r_q[N-1:1]};
        MODE_ROL:   w_q_next = {r_q[N-2:0], r_q[N-1]};
        MODE_BURST: begin
          // Load now; the following N edges shift the word out LSB first.
          w_q_next     = D;
          w_state_next = ST_BURST;
          w_cnt_next   = '0;
        end
        default:    w_q_next = r_q;
      endcase
    end
  end

  // FSM state, bit counter and completion pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  assign Q    = r_q;
  assign sout = r_q[0];
  assign busy = (r_state == ST_BURST);
  assign done = r_done;

endmodule
